// File: rtl/pixel_mem_ctrl.sv
// pixel_mem_ctrl: MEM-stage controller for the banked pixel memory.
//   Decodes linear load addresses into bank-select/offset reads of the input pixel banks.
//   Sequences stores into the output frame buffer through a wrapping write pointer.
//   A round-robin arbiter shares the single memory slot between the load and store ports.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ld_req_i/ld_addr_i/ld_rd_i    load request, linear address, destination tag
//   ld_ready_o                    load accepted this cycle
//   ld_valid_o/ld_data_o          one-cycle response strobe, zero-extended pixel
//   ld_rd_out_o/ld_err_o          echoed tag, out-of-range flag
//   st_req_i/st_data_i/st_ready_o store request, pixel, accepted this cycle
//   bank_rd_en_o/bank_sel_o/bank_addr_o/bank_rdata_i   input bank read port
//   out_we_o/out_addr_o/out_wdata_o                    output frame buffer write port
//   frame_done_o                  pulses with the final write of a frame
//   pix_count_o                   current write pointer
module pixel_mem_ctrl #(
    parameter int unsigned BANK_DEPTH  = 65000,
    parameter int unsigned NUM_BANKS   = 10,
    parameter int unsigned LAST_DEPTH  = 29392,
    parameter int unsigned PIXEL_COUNT = 304200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ld_req_i,
    input  logic [31:0] ld_addr_i,
    input  logic [6:0]  ld_rd_i,
    output logic        ld_ready_o,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    output logic [6:0]  ld_rd_out_o,
    output logic        ld_err_o,
    input  logic        st_req_i,
    input  logic [7:0]  st_data_i,
    output logic        st_ready_o,
    output logic        bank_rd_en_o,
    output logic [3:0]  bank_sel_o,
    output logic [15:0] bank_addr_o,
    input  logic [7:0]  bank_rdata_i,
    output logic        out_we_o,
    output logic [18:0] out_addr_o,
    output logic [7:0]  out_wdata_o,
    output logic        frame_done_o,
    output logic [18:0] pix_count_o
);
    localparam int unsigned ADDR_LIMIT = (NUM_BANKS - 1) * BANK_DEPTH + LAST_DEPTH;
    localparam logic GrantLoad  = 1'b0;
    localparam logic GrantStore = 1'b1;

    typedef enum logic [1:0] {StIdle, StRdIssue, StRdWait, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [6:0]  tag_q, tag_d;
    logic        ld_valid_q, ld_valid_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [6:0]  ld_rd_out_q, ld_rd_out_d;
    logic        ld_err_q, ld_err_d;
    logic        bank_rd_en_q, bank_rd_en_d;
    logic [3:0]  bank_sel_q, bank_sel_d;
    logic [15:0] bank_addr_q, bank_addr_d;
    logic        out_we_q, out_we_d;
    logic [18:0] out_addr_q, out_addr_d;
    logic [7:0]  out_wdata_q, out_wdata_d;
    logic        frame_done_q, frame_done_d;
    logic [18:0] pix_count_q, pix_count_d;

    logic        grant_ld, grant_st;
    logic        addr_ok;
    logic [3:0]  dec_bank;
    logic [31:0] dec_off;

    // Bank decode as a compare chain: the highest bank base not above the address wins.
    always_comb begin
        dec_bank = '0;
        dec_off  = ld_addr_i;
        for (int unsigned k = 1; k < NUM_BANKS; k++) begin
            if (ld_addr_i >= k * BANK_DEPTH) begin
                dec_bank = 4'(k);
                dec_off  = ld_addr_i - k * BANK_DEPTH;
            end
        end
    end

    assign addr_ok = (ld_addr_i < ADDR_LIMIT);

    // Round robin only matters under contention; a lone requester always wins.
    always_comb begin
        grant_ld = 1'b0;
        grant_st = 1'b0;
        if (state_q == StIdle && !rst_i) begin
            if (ld_req_i && st_req_i) begin
                grant_ld = (last_grant_q == GrantStore);
                grant_st = (last_grant_q == GrantLoad);
            end else begin
                grant_ld = ld_req_i;
                grant_st = st_req_i;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tag_d        = tag_q;
        ld_valid_d   = 1'b0;
        ld_data_d    = ld_data_q;
        ld_rd_out_d  = ld_rd_out_q;
        ld_err_d     = 1'b0;
        bank_rd_en_d = 1'b0;
        bank_sel_d   = bank_sel_q;
        bank_addr_d  = bank_addr_q;
        out_we_d     = 1'b0;
        out_addr_d   = out_addr_q;
        out_wdata_d  = out_wdata_q;
        frame_done_d = 1'b0;
        pix_count_d  = pix_count_q;
        unique case (state_q)
            StIdle: begin
                if (grant_ld) begin
                    last_grant_d = GrantLoad;
                    tag_d        = ld_rd_i;
                    if (addr_ok) begin
                        bank_rd_en_d = 1'b1;
                        bank_sel_d   = dec_bank;
                        bank_addr_d  = dec_off[15:0];
                        state_d      = StRdIssue;
                    end else begin
                        // Out of range: skip the bank read and answer with an error.
                        ld_valid_d  = 1'b1;
                        ld_err_d    = 1'b1;
                        ld_data_d   = '0;
                        ld_rd_out_d = ld_rd_i;
                        state_d     = StResp;
                    end
                end else if (grant_st) begin
                    last_grant_d = GrantStore;
                    out_we_d     = 1'b1;
                    out_addr_d   = pix_count_q;
                    out_wdata_d  = st_data_i;
                    if (pix_count_q == 19'(PIXEL_COUNT - 1)) begin
                        pix_count_d  = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        pix_count_d = pix_count_q + 19'd1;
                    end
                end
            end
            StRdIssue: state_d = StRdWait;
            StRdWait: begin
                ld_valid_d  = 1'b1;
                ld_data_d   = {24'b0, bank_rdata_i};
                ld_rd_out_d = tag_q;
                state_d     = StResp;
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= GrantStore;
            tag_q        <= '0;
            ld_valid_q   <= 1'b0;
            ld_data_q    <= '0;
            ld_rd_out_q  <= '0;
            ld_err_q     <= 1'b0;
            bank_rd_en_q <= 1'b0;
            bank_sel_q   <= '0;
            bank_addr_q  <= '0;
            out_we_q     <= 1'b0;
            out_addr_q   <= '0;
            out_wdata_q  <= '0;
            frame_done_q <= 1'b0;
            pix_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            ld_valid_q   <= ld_valid_d;
            ld_data_q    <= ld_data_d;
            ld_rd_out_q  <= ld_rd_out_d;
            ld_err_q     <= ld_err_d;
            bank_rd_en_q <= bank_rd_en_d;
            bank_sel_q   <= bank_sel_d;
            bank_addr_q  <= bank_addr_d;
            out_we_q     <= out_we_d;
            out_addr_q   <= out_addr_d;
            out_wdata_q  <= out_wdata_d;
            frame_done_q <= frame_done_d;
            pix_count_q  <= pix_count_d;
        end
    end

    assign ld_ready_o   = grant_ld;
    assign st_ready_o   = grant_st;
    assign ld_valid_o   = ld_valid_q;
    assign ld_data_o    = ld_data_q;
    assign ld_rd_out_o  = ld_rd_out_q;
    assign ld_err_o     = ld_err_q;
    assign bank_rd_en_o = bank_rd_en_q;
    assign bank_sel_o   = bank_sel_q;
    assign bank_addr_o  = bank_addr_q;
    assign out_we_o     = out_we_q;
    assign out_addr_o   = out_addr_q;
    assign out_wdata_o  = out_wdata_q;
    assign frame_done_o = frame_done_q;
    assign pix_count_o  = pix_count_q;

endmodule

// File: tb/tb_pixel_mem_ctrl.sv
// tb_pixel_mem_ctrl: randomized self-checking bench for pixel_mem_ctrl.
//   A behavioural bank memory answers reads one cycle after bank_rd_en; expected
//   bank/offset come from plain division and modulo of the linear address.
module tb_pixel_mem_ctrl;
    // Short frame so a full wrap fits in a brief run.
    localparam int unsigned PIX   = 300;
    localparam int unsigned BDEP  = 65000;
    localparam int unsigned LIMIT = 614392;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [6:0]  ld_rd = '0;
    logic        ld_ready, ld_valid, ld_err;
    logic [31:0] ld_data;
    logic [6:0]  ld_rd_out;
    logic        st_req = 1'b0;
    logic [7:0]  st_data = '0;
    logic        st_ready;
    logic        bank_rd_en;
    logic [3:0]  bank_sel;
    logic [15:0] bank_addr;
    logic [7:0]  bank_rdata = '0;
    logic        out_we;
    logic [18:0] out_addr;
    logic [7:0]  out_wdata;
    logic        frame_done;
    logic [18:0] pix_count;

    int n_checks = 0;
    int n_pass   = 0;

    pixel_mem_ctrl #(.PIXEL_COUNT(PIX)) dut (
        .clk_i(clk), .rst_i(rst),
        .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_rd_i(ld_rd),
        .ld_ready_o(ld_ready), .ld_valid_o(ld_valid), .ld_data_o(ld_data),
        .ld_rd_out_o(ld_rd_out), .ld_err_o(ld_err),
        .st_req_i(st_req), .st_data_i(st_data), .st_ready_o(st_ready),
        .bank_rd_en_o(bank_rd_en), .bank_sel_o(bank_sel), .bank_addr_o(bank_addr),
        .bank_rdata_i(bank_rdata),
        .out_we_o(out_we), .out_addr_o(out_addr), .out_wdata_o(out_wdata),
        .frame_done_o(frame_done), .pix_count_o(pix_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_fn(input logic [3:0] b, input logic [15:0] o);
        return 8'(o * 16'd7) ^ {b, 4'hA} ^ o[15:8];
    endfunction

    // Bank contents model: data appears the cycle after the read strobe.
    always @(posedge clk) bank_rdata <= bank_rd_en ? pix_fn(bank_sel, bank_addr) : 8'h00;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1; ld_req = 1'b0; st_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [6:0] tag);
        int         waited;
        bit         in_range;
        logic [3:0] e_sel;
        logic [15:0] e_off;
        logic [31:0] e_data;
        in_range = (addr < LIMIT);
        e_sel    = 4'(addr / BDEP);
        e_off    = 16'(addr % BDEP);
        e_data   = {24'b0, pix_fn(e_sel, e_off)};
        ld_req = 1'b1; ld_addr = addr; ld_rd = tag;
        #1;
        waited = 0;
        while (ld_ready !== 1'b1 && waited < 10) begin
            @(negedge clk); #1; waited++;
        end
        n_checks++;
        if (ld_ready !== 1'b1) $display("FAIL load_grant addr=%0d: ld_ready=%b want 1", addr, ld_ready);
        else n_pass++;
        @(negedge clk);
        ld_req = 1'b0;
        if (in_range) begin
            n_checks++;
            if (bank_rd_en !== 1'b1 || bank_sel !== e_sel || bank_addr !== e_off)
                $display("FAIL bank_issue addr=%0d: en=%b sel=%0d off=%0d want 1/%0d/%0d",
                         addr, bank_rd_en, bank_sel, bank_addr, e_sel, e_off);
            else n_pass++;
            n_checks++;
            if (ld_valid !== 1'b0) $display("FAIL early_valid addr=%0d: ld_valid=%b want 0", addr, ld_valid);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (bank_rd_en !== 1'b0 || ld_valid !== 1'b0)
                $display("FAIL rd_wait addr=%0d: en=%b valid=%b want 0/0", addr, bank_rd_en, ld_valid);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (ld_valid !== 1'b1 || ld_err !== 1'b0 || ld_data !== e_data || ld_rd_out !== tag)
                $display("FAIL load_resp addr=%0d: v=%b e=%b d=%h tag=%0d want 1/0/%h/%0d",
                         addr, ld_valid, ld_err, ld_data, ld_rd_out, e_data, tag);
            else n_pass++;
        end else begin
            n_checks++;
            if (bank_rd_en !== 1'b0 || ld_valid !== 1'b1 || ld_err !== 1'b1 ||
                ld_data !== 32'd0 || ld_rd_out !== tag)
                $display("FAIL err_resp addr=%0d: en=%b v=%b e=%b d=%h tag=%0d want 0/1/1/0/%0d",
                         addr, bank_rd_en, ld_valid, ld_err, ld_data, ld_rd_out, tag);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (ld_valid !== 1'b0 || ld_err !== 1'b0 || bank_rd_en !== 1'b0)
            $display("FAIL strobe_clear addr=%0d: v=%b e=%b en=%b want 0/0/0",
                     addr, ld_valid, ld_err, bank_rd_en);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_req = 1'b1; st_req = 1'b1; ld_addr = 32'd100;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (ld_ready !== 1'b0 || st_ready !== 1'b0)
            $display("FAIL reset_ready: ld=%b st=%b want 0/0", ld_ready, st_ready);
        else n_pass++;
        n_checks++;
        if ({ld_valid, ld_err, bank_rd_en, out_we, frame_done} !== 5'b0 || ld_data !== 32'd0 ||
            ld_rd_out !== 7'd0 || bank_sel !== 4'd0 || bank_addr !== 16'd0 ||
            out_addr !== 19'd0 || out_wdata !== 8'd0 || pix_count !== 19'd0)
            $display("FAIL reset_outputs: v=%b e=%b en=%b we=%b fd=%b d=%h pc=%0d want all zero",
                     ld_valid, ld_err, bank_rd_en, out_we, frame_done, ld_data, pix_count);
        else n_pass++;
        ld_req = 1'b0; st_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [6];
        addrs[0] = 32'd130005; addrs[1] = 32'd64999;  addrs[2] = 32'd65000;
        addrs[3] = 32'd614391; addrs[4] = 32'd614392; addrs[5] = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) do_load(addrs[i], 7'(i + 3));
    endtask

    task automatic test_random_loads();
        for (int i = 0; i < 24; i++) do_load(32'($urandom_range(0, 700000)), 7'($urandom));
    endtask

    task automatic test_frame();
        int         exp_ptr;
        int         pulses;
        logic [7:0] prev;
        apply_reset();
        exp_ptr = 0; pulses = 0;
        st_req = 1'b1; st_data = 8'($urandom);
        for (int i = 0; i < PIX + 3; i++) begin
            #1;
            n_checks++;
            if (st_ready !== 1'b1) $display("FAIL store_ready i=%0d: st_ready=%b want 1", i, st_ready);
            else n_pass++;
            prev = st_data;
            @(negedge clk);
            n_checks++;
            if (out_we !== 1'b1 || out_addr !== 19'(exp_ptr) || out_wdata !== prev ||
                frame_done !== (exp_ptr == PIX - 1))
                $display("FAIL store_write i=%0d: we=%b a=%0d d=%h fd=%b want 1/%0d/%h/%b",
                         i, out_we, out_addr, out_wdata, frame_done, exp_ptr, prev,
                         (exp_ptr == PIX - 1));
            else n_pass++;
            if (frame_done === 1'b1) pulses++;
            exp_ptr = (exp_ptr + 1) % PIX;
            n_checks++;
            if (pix_count !== 19'(exp_ptr))
                $display("FAIL pix_count i=%0d: got %0d want %0d", i, pix_count, exp_ptr);
            else n_pass++;
            st_data = 8'($urandom);
        end
        st_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_we !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL store_idle: we=%b fd=%b want 0/0", out_we, frame_done);
        else n_pass++;
        n_checks++;
        if (pulses != 1) $display("FAIL frame_pulses: got %0d want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int exp_c;
        bit exp_ld;
        bit g;
        rst = 1'b1; ld_req = 1'b1; st_req = 1'b1;
        ld_addr = 32'd200000; ld_rd = 7'd9; st_data = 8'h5C;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        exp_c = 0; exp_ld = 1'b1;
        // A load occupies the slot for four cycles, a store for one.
        for (int c = 0; c < 30; c++) begin
            g = (c == exp_c);
            n_checks++;
            if (ld_ready !== (g && exp_ld) || st_ready !== (g && !exp_ld))
                $display("FAIL rr_grant cyc=%0d: ld=%b st=%b want %b/%b",
                         c, ld_ready, st_ready, (g && exp_ld), (g && !exp_ld));
            else n_pass++;
            if (g) begin
                exp_c  = c + (exp_ld ? 4 : 1);
                exp_ld = !exp_ld;
            end
            @(negedge clk); #1;
        end
        ld_req = 1'b0; st_req = 1'b0;
    endtask

    task automatic test_store_during_load();
        apply_reset();
        ld_req = 1'b1; ld_addr = 32'd70000; ld_rd = 7'd33;
        #1;
        n_checks++;
        if (ld_ready !== 1'b1) $display("FAIL sdl_grant: ld_ready=%b want 1", ld_ready);
        else n_pass++;
        @(negedge clk);
        ld_req = 1'b0;
        @(negedge clk);
        st_req = 1'b1; st_data = 8'h3E;
        #1;
        n_checks++;
        if (st_ready !== 1'b0) $display("FAIL sdl_block_wait: st_ready=%b want 0", st_ready);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (st_ready !== 1'b0 || ld_valid !== 1'b1)
            $display("FAIL sdl_block_resp: st_ready=%b ld_valid=%b want 0/1", st_ready, ld_valid);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (st_ready !== 1'b1) $display("FAIL sdl_grant_idle: st_ready=%b want 1", st_ready);
        else n_pass++;
        @(negedge clk);
        st_req = 1'b0;
        n_checks++;
        if (out_we !== 1'b1 || out_addr !== 19'd0 || out_wdata !== 8'h3E)
            $display("FAIL sdl_write: we=%b a=%0d d=%h want 1/0/3e", out_we, out_addr, out_wdata);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ld_req = 1'b1; ld_addr = 32'd12345; ld_rd = 7'd77;
        @(negedge clk);
        ld_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ld_valid !== 1'b0 || bank_rd_en !== 1'b0 || ld_data !== 32'd0 || ld_rd_out !== 7'd0)
                $display("FAIL rst_mid_load i=%0d: v=%b en=%b d=%h tag=%0d want 0/0/0/0",
                         i, ld_valid, bank_rd_en, ld_data, ld_rd_out);
            else n_pass++;
            @(negedge clk);
        end
        st_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            st_data = 8'($urandom);
            @(negedge clk);
        end
        st_req = 1'b0;
        n_checks++;
        if (pix_count !== 19'd100) $display("FAIL pre_rst_count: got %0d want 100", pix_count);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (pix_count !== 19'd0 || out_we !== 1'b0 || frame_done !== 1'b0 ||
            out_addr !== 19'd0 || out_wdata !== 8'd0)
            $display("FAIL rst_mid_frame: pc=%0d we=%b fd=%b a=%0d d=%h want 0/0/0/0/0",
                     pix_count, out_we, frame_done, out_addr, out_wdata);
        else n_pass++;
        st_req = 1'b1; st_data = 8'hC3;
        @(negedge clk);
        st_req = 1'b0;
        n_checks++;
        if (out_we !== 1'b1 || out_addr !== 19'd0 || out_wdata !== 8'hC3 || pix_count !== 19'd1)
            $display("FAIL post_rst_store: we=%b a=%0d d=%h pc=%0d want 1/0/c3/1",
                     out_we, out_addr, out_wdata, pix_count);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_random_loads();
        test_frame();
        test_back_to_back();
        test_store_during_load();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
